// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory port, redirect input and decode handoff.
// master = fetch_queue side, slave = pipeline/memory side.
interface fetch_queue_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            ex_mem_pc_src;
   logic [XLEN-1:0] ex_mem_npc;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_data;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_npc;
   logic [CW-1:0]   fq_count;

   modport master (
      input  ex_mem_pc_src, ex_mem_npc, imem_data, id_ready,
      output imem_addr, id_valid, id_instr, id_pc, id_npc, fq_count
   );

   modport slave (
      output ex_mem_pc_src, ex_mem_npc, imem_data, id_ready,
      input  imem_addr, id_valid, id_instr, id_pc, id_npc, fq_count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally and queues
// {pc, instr} in a DEPTH-entry FIFO handed to decode with valid/ready; redirect flushes.
module fetch_queue #(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst_n,
   fetch_queue_if.master fq
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [XLEN-1:0] mem_instr [DEPTH];

   logic redirect, full, valid, pop, push;

   assign redirect = fq.ex_mem_pc_src;
   assign full     = (count_q == CW'(DEPTH));
   assign valid    = (count_q != '0);
   assign pop      = valid && fq.id_ready;
   // A pop frees a slot this cycle, so a full queue can still accept the fetch.
   assign push     = !redirect && (!full || pop);

   always_comb begin
      pc_d    = pc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (redirect) begin
         pc_d    = fq.ex_mem_npc & ~XLEN'(3);
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (push) begin
            pc_d = pc_q + XLEN'(4);
            wr_d = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   // Storage is data-only; occupancy comes from count_q, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_q]    <= pc_q;
         mem_instr[wr_q] <= fq.imem_data;
      end
   end

   assign fq.imem_addr = pc_q;
   assign fq.id_valid  = valid;
   assign fq.id_pc     = mem_pc[rd_q];
   assign fq.id_instr  = mem_instr[rd_q];
   assign fq.id_npc    = mem_pc[rd_q] + XLEN'(4);
   assign fq.fq_count  = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH 4, RESET_PC 0): reset, fill, drain,
// redirect, PC wrap and asynchronous reset.
module tb_fetch_queue;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .XLEN    (XLEN),
      .DEPTH   (DEPTH),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .fq   (bus.master)
   );

   // Memory model: word i holds 0x1000_0000 + i.
   assign bus.imem_data = 32'h1000_0000 + (bus.imem_addr >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input int cnt);
      check_eq({tag, " valid"}, 32'(bus.id_valid), 32'd1);
      check_eq({tag, " pc"},    bus.id_pc,         pc);
      check_eq({tag, " npc"},   bus.id_npc,        pc + 32'd4);
      check_eq({tag, " instr"}, bus.id_instr,      word_at(pc));
      check_eq({tag, " count"}, 32'(bus.fq_count), 32'(cnt));
   endtask

   initial begin
      logic [31:0] exp_addr;
      n_checks          = 0;
      n_fail            = 0;
      rst_n             = 1'b0;
      bus.id_ready      = 1'b0;
      bus.ex_mem_pc_src = 1'b0;
      bus.ex_mem_npc    = '0;

      @(negedge clk);
      @(negedge clk);
      check_eq("reset valid", 32'(bus.id_valid), 32'd0);
      check_eq("reset count", 32'(bus.fq_count), 32'd0);
      check_eq("reset addr",  bus.imem_addr,     32'h0);

      // Back-pressure fill from reset release.
      rst_n = 1'b1;
      check_eq("release valid", 32'(bus.id_valid), 32'd0);
      for (int i = 0; i < 10; i++) begin
         exp_addr = (i < 3) ? 32'(4 * (i + 1)) : 32'h10;
         step();
         check_head($sformatf("fill%0d", i), 32'h0, (i < 3) ? i + 1 : 4);
         check_eq($sformatf("fill%0d addr", i), bus.imem_addr, exp_addr);
      end

      // Drain: full with push and pop every cycle, no gap.
      bus.id_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check_head($sformatf("drain%0d", k), 32'(4 * k), 4);
         check_eq($sformatf("drain%0d addr", k), bus.imem_addr, 32'h10 + 32'(4 * k));
      end

      // Redirect coincident with pop of head 0x18.
      bus.ex_mem_pc_src = 1'b1;
      bus.ex_mem_npc    = 32'h0000_0100;
      step();
      bus.ex_mem_pc_src = 1'b0;
      bus.id_ready      = 1'b0;
      check_eq("redir-pop valid", 32'(bus.id_valid), 32'd0);
      check_eq("redir-pop count", 32'(bus.fq_count), 32'd0);
      check_eq("redir-pop addr",  bus.imem_addr,     32'h100);
      step();
      check_head("redir-pop tgt", 32'h100, 1);
      step();
      step();
      check_head("three queued", 32'h100, 3);

      // Redirect flush with 3 entries, unaligned target.
      bus.ex_mem_pc_src = 1'b1;
      bus.ex_mem_npc    = 32'h0000_0203;
      step();
      bus.ex_mem_pc_src = 1'b0;
      bus.id_ready      = 1'b1;
      check_eq("flush valid", 32'(bus.id_valid), 32'd0);
      check_eq("flush count", 32'(bus.fq_count), 32'd0);
      check_eq("flush addr",  bus.imem_addr,     32'h200);
      step();
      check_head("flush tgt", 32'h200, 1);

      // PC wrap.
      bus.ex_mem_pc_src = 1'b1;
      bus.ex_mem_npc    = 32'hFFFF_FFF8;
      step();
      bus.ex_mem_pc_src = 1'b0;
      check_eq("wrap gap valid", 32'(bus.id_valid), 32'd0);
      step();
      check_head("wrap0", 32'hFFFF_FFF8, 1);
      step();
      check_head("wrap1", 32'hFFFF_FFFC, 1);
      check_eq("wrap1 npc0", bus.id_npc, 32'h0);
      step();
      check_head("wrap2", 32'h0, 1);

      // Asynchronous reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async valid", 32'(bus.id_valid), 32'd0);
      check_eq("async count", 32'(bus.fq_count), 32'd0);
      check_eq("async addr",  bus.imem_addr,     32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_head("post-reset", 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue, replacing the fixed single-entry IF/ID register with a DEPTH-entry FIFO and a valid/ready handoff to decode. It owns the PC, drives a combinational-read instruction memory port, and queues {pc, npc, instr} tuples. It supports decode back-pressure (stall) and branch redirect from EX/MEM, which flushes the queue. It sits between the PC/instruction memory and the decode stage of the pipeline.

## Interface
- XLEN, 32, PC/instruction width (≥ 8).
- DEPTH, 4, queue entries; power of two, ≥ 2.
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ex_mem_pc_src  input  1  redirect request; valid for one cycle.
- ex_mem_npc  input  XLEN  redirect target; bits [1:0] ignored, forced to 0.
- imem_addr  output  XLEN  fetch address, equals current PC.
- imem_data  input  XLEN  instruction at imem_addr, same cycle (combinational read).
- id_valid  output  1  queue head holds a valid instruction.
- id_ready  input  1  decode accepts head this cycle.
- id_instr  output  XLEN  head instruction.
- id_pc  output  XLEN  head instruction's address.
- id_npc  output  XLEN  head pc + 4.
- fq_count  output  $clog2(DEPTH)+1  occupied entries.

## Operation
- State: PC register, DEPTH-entry storage array {pc, instr}, read pointer, write pointer, count.
- pop = id_valid && id_ready.
- push = !redirect && (count < DEPTH || pop). Push writes {PC, imem_data} at write pointer; PC <= PC + 4.
- No push: PC holds.
- Redirect (ex_mem_pc_src = 1):
  - Highest priority: PC <= {ex_mem_npc[XLEN-1:2], 2'b00}.
  - Read pointer, write pointer and count cleared; no push that cycle.
  - A pop in the same cycle is a completed transfer; the entry is still discarded from the queue.
- id_valid = (count != 0). id_instr/id_pc come from the head entry; id_npc = id_pc + 4, modulo 2^XLEN.
- When id_valid = 0, id_instr/id_pc/id_npc are don't-care, and the bench must not check them.
- Full with pop: push and pop in the same cycle; count is unchanged.
- Full without pop: PC stalls; imem_addr is held stable.
- Empty: pop is impossible; push only.
- Pointers are log2(DEPTH) bits and wrap naturally.
- PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000. No fault is raised.
- Count rules:
  - push && !pop: count + 1.
  - pop && !push && !redirect: count − 1.
  - redirect: 0.

## Timing
- Reset values (async on rst_n low): PC = RESET_PC, imem_addr = RESET_PC, pointers = 0, fq_count = 0, id_valid = 0. Storage contents are not reset.
- Reset mid-operation discards all entries and any in-flight redirect immediately (asynchronous).
- First edge after rst_n rises: push of RESET_PC. id_valid = 1 in the following cycle.
- Fetch-to-decode latency: 1 cycle when the queue is empty.
- Redirect latency:
  - Redirect sampled at edge N.
  - Target fetched in cycle N+1.
  - Target appears at the head with id_valid = 1 after edge N+1.
  - id_valid = 0 in the cycle between edges N and N+1.
- Handshake:
  - id_instr/id_pc/id_npc are stable while id_valid && !id_ready, unless a redirect occurs.
  - id_valid is never deasserted without a pop or a redirect.
- Throughput: one instruction per cycle sustained with id_ready held at 1.
- Combinational paths: id_ready → push enable → PC next. There is no path from id_ready to imem_addr in the same cycle.

## Test plan
- Reset and streaming:
  - Stimulus: RESET_PC = 0, imem word i = 0x1000_0000 + i, id_ready = 1.
  - Required: first id_valid one cycle after reset release; id_pc 0, 4, 8, … consecutive; id_npc = id_pc + 4; id_instr matches the memory word.
- Back-pressure fill (DEPTH = 4):
  - Stimulus: id_ready = 0 for 10 cycles.
  - Required: fq_count reaches 4 and holds; imem_addr frozen at 0x10; head stays id_pc = 0.
  - On release: entries 0x0–0xC drain in order with no gap, then 0x10.
- Full with simultaneous push/pop:
  - Stimulus: queue full, id_ready = 1 for one cycle.
  - Required: fq_count stays 4; PC advances by 4.
- Redirect flush:
  - Stimulus: 3 entries queued, ex_mem_pc_src = 1 with ex_mem_npc = 0x0000_0203.
  - Required: next cycle fq_count = 0 and id_valid = 0; the cycle after, id_pc = 0x200 and id_npc = 0x204.
- Redirect coincident with pop:
  - Stimulus: ex_mem_pc_src = 1 and id_ready = 1 with id_valid = 1 in the same cycle.
  - Required: the head is consumed once; no stale entry appears afterwards.
- Wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFF8.
  - Required: id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; npc for 0xFFFF_FFFC = 0x0.
  - Stimulus: assert rst_n low between clock edges.
  - Required: id_valid and fq_count go to 0 without waiting for a clock edge.
